// File: rtl/renode_ahb_pkg.sv
// Shared AHB-Lite types and helpers for the Renode AHB arbiter.
// Contents: AHB transfer/burst/response encodings, arbiter FSM states,
// strobe and alignment helpers (valid for bus widths up to 64 bits).
package renode_ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } transfer_type_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000
  } burst_type_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } response_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA,
    ARB_REJECT
  } arb_state_e;

  localparam int unsigned MAX_STRB_W = 8;

  // Byte lanes touched by a transfer of 2**size bytes at the given byte offset.
  function automatic logic [MAX_STRB_W-1:0] size_to_strobe(input logic [2:0] size,
                                                            input logic [2:0] offset);
    logic [15:0] ones;
    ones = (16'd1 << (5'd1 << size[1:0])) - 16'd1;
    return MAX_STRB_W'(ones << offset);
  endfunction

  // True when the low address bits are a multiple of 2**size (size <= 3).
  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] addr_lo);
    logic [3:0] mask;
    mask = (4'd1 << size[1:0]) - 4'd1;
    return ((mask & {1'b0, addr_lo}) == 4'd0);
  endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req (pending requests), ptr (highest-priority index),
//        grant (one-hot), grant_idx (binary index of grant), any (some request pending).
module renode_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Scan N positions starting at ptr, wrapping; first pending request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && req[(32'(ptr) + k) % N]) begin
        any       = 1'b1;
        grant_idx = IDX_W'((32'(ptr) + k) % N);
        grant     = N'(1) << ((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/renode_ahb_arbiter.sv
// Shares one AHB-Lite manager port between NUM_REQ request/response clients.
// One single transfer in flight, round-robin grant, local reject of bad size/alignment.
// Ports:
//   hclk/hreset                     clock, synchronous active-high reset
//   req_valid/ready/addr/write/size/wdata   per-client request channel (packed)
//   resp_valid/rdata/error          response pulse to the owning client
//   haddr/htrans/hwrite/hsize/hburst/hwstrb/hwdata   AHB manager outputs
//   hrdata/hready/hresp             AHB subordinate inputs
//   stall_flag                      sticky: a phase waited STALL_LIMIT cycles
module renode_ahb_arbiter
  import renode_ahb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_LIMIT = 256
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*3-1:0]    req_size,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_error,
  output logic [ADDR_W-1:0]       haddr,
  output logic [1:0]              htrans,
  output logic                    hwrite,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [DATA_W/8-1:0]     hwstrb,
  output logic [DATA_W-1:0]       hwdata,
  input  logic [DATA_W-1:0]       hrdata,
  input  logic                    hready,
  input  logic                    hresp,
  output logic                    stall_flag
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(STALL_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [STRB_W-1:0]   hwstrb_q, hwstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  transfer_type_e      htrans_q, htrans_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                stall_flag_q, stall_flag_d;
  logic [NUM_REQ-1:0]  req_ready_c;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_size;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_ok;

  renode_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Fields of the requester the arbiter currently points at.
  assign sel_addr  = req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_size  = req_size[32'(arb_idx)*3 +: 3];
  assign sel_write = req_write[arb_idx];
  assign sel_wdata = req_wdata[32'(arb_idx)*DATA_W +: DATA_W];
  assign sel_ok    = (sel_size <= 3'(OFF_W)) && is_aligned(sel_size, sel_addr[2:0]);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    hwstrb_d     = hwstrb_q;
    wdata_d      = wdata_q;
    hwdata_d     = hwdata_q;
    htrans_d     = htrans_q;
    resp_valid_d = '0;
    resp_rdata_d = '0;
    resp_error_d = 1'b0;
    stall_cnt_d  = '0;
    stall_flag_d = stall_flag_q;
    req_ready_c  = '0;

    case (state_q)
      ARB_IDLE: begin
        if (arb_any && !hreset) begin
          req_ready_c = arb_grant;
          owner_d     = arb_idx;
          ptr_d       = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
          wdata_d     = sel_wdata;
          hwrite_d    = sel_write;
          if (sel_ok) begin
            haddr_d  = sel_addr;
            hsize_d  = sel_size;
            hwstrb_d = STRB_W'(size_to_strobe(sel_size, 3'(sel_addr[OFF_W-1:0])));
            htrans_d = TRANS_NONSEQ;
            state_d  = ARB_ADDR;
          end else begin
            state_d  = ARB_REJECT;
          end
        end
      end

      ARB_REJECT: begin
        resp_valid_d = NUM_REQ'(1) << owner_q;
        resp_error_d = 1'b1;
        state_d      = ARB_IDLE;
      end

      ARB_ADDR: begin
        if (hready) begin
          htrans_d = TRANS_IDLE;
          hwdata_d = hwrite_q ? wdata_q : '0;
          state_d  = ARB_DATA;
        end
      end

      ARB_DATA: begin
        if (hready) begin
          resp_valid_d = NUM_REQ'(1) << owner_q;
          resp_error_d = (hresp == RESP_ERROR);
          resp_rdata_d = (!hwrite_q && (hresp == RESP_OKAY)) ? hrdata : '0;
          hwdata_d     = '0;
          state_d      = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    // Wait-state watchdog: consecutive hready-low cycles within one phase.
    if ((state_q == ARB_ADDR || state_q == ARB_DATA) && !hready) begin
      stall_cnt_d = (stall_cnt_q == CNT_W'(STALL_LIMIT)) ? stall_cnt_q
                                                         : stall_cnt_q + CNT_W'(1);
      if (stall_cnt_d == CNT_W'(STALL_LIMIT)) begin
        stall_flag_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      hwstrb_q     <= '0;
      wdata_q      <= '0;
      hwdata_q     <= '0;
      htrans_q     <= TRANS_IDLE;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      stall_cnt_q  <= '0;
      stall_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      hwstrb_q     <= hwstrb_d;
      wdata_q      <= wdata_d;
      hwdata_q     <= hwdata_d;
      htrans_q     <= htrans_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_flag_q <= stall_flag_d;
    end
  end

  // req_ready is the same-cycle accept strobe of the request handshake.
  assign req_ready  = req_ready_c;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign haddr      = haddr_q;
  assign htrans     = htrans_q;
  assign hwrite     = hwrite_q;
  assign hsize      = hsize_q;
  assign hburst     = BURST_SINGLE;
  assign hwstrb     = hwstrb_q;
  assign hwdata     = hwdata_q;
  assign stall_flag = stall_flag_q;

endmodule

// File: tb/tb_renode_ahb_arbiter.sv
// Directed self-checking bench for renode_ahb_arbiter with a response scoreboard
// and a small wait-state/error-capable AHB subordinate model.
module tb_renode_ahb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [N-1:0]    req_valid, req_ready, req_write, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*3-1:0]  req_size;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata;
  logic            resp_error;
  logic [AW-1:0]   haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize, hburst;
  logic [DW/8-1:0] hwstrb;
  logic [DW-1:0]   hwdata, hrdata;
  logic            hready, hresp, stall_flag;

  renode_ahb_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STALL_LIMIT(2)
  ) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwstrb(hwstrb), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .stall_flag(stall_flag)
  );

  always #5 hclk = ~hclk;

  // Subordinate model: cfg_wait hready-low cycles per data phase, optional error.
  logic        dp_active;
  logic [31:0] dp_addr;
  int          dp_wait = 0;
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0, cfg_fixed = 1'b0;
  logic [31:0] cfg_rdata = '0;

  assign hready = !(dp_active && dp_wait > 0);
  assign hresp  = dp_active && cfg_err;
  assign hrdata = !dp_active ? '0 : (cfg_fixed ? cfg_rdata : (dp_addr ^ 32'h5A5A_0000));

  always @(posedge hclk) begin
    if (hreset) begin
      dp_active <= 1'b0;
    end else begin
      if (dp_active && hready) dp_active <= 1'b0;
      else if (dp_active)      dp_wait <= dp_wait - 1;
      if (htrans == 2'b10 && hready) begin
        dp_active <= 1'b1;
        dp_addr   <= haddr;
        dp_wait   <= cfg_wait;
      end
    end
  end

  typedef struct {
    int          client;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_resp_cyc = 0;
  int   t_grant = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop and compare the scoreboard whenever a response pulse appears.
  task automatic check_resp();
    exp_t e;
    if (resp_valid !== '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        last_resp_cyc = cyc;
        chk("resp_valid", 64'(resp_valid), 64'(N'(1) << e.client));
        chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        chk("resp_error", 64'(resp_error), 64'(e.err));
      end
    end
  endtask

  task automatic cycle();
    @(posedge hclk);
    #1;
    cyc++;
    check_resp();
  endtask

  task automatic set_req(input int c, input logic [31:0] a, input logic w,
                         input logic [2:0] s, input logic [31:0] d);
    req_valid[c]            = 1'b1;
    req_addr[c*AW +: AW]    = a;
    req_write[c]            = w;
    req_size[c*3 +: 3]      = s;
    req_wdata[c*DW +: DW]   = d;
  endtask

  // Wait (bounded) for client c to be granted, then record the expected response.
  task automatic wait_grant(input int c, input logic [31:0] exp_rd, input logic exp_err);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready[c]) begin
        got = 1'b1;
        break;
      end
      cycle();
    end
    chk($sformatf("grant_c%0d", c), 64'(got), 64'd1);
    if (got) begin
      chk("ready_onehot", 64'(req_ready), 64'(N'(1) << c));
      sb.push_back('{client: c, rdata: exp_rd, err: exp_err});
      t_grant = cyc;
    end
  endtask

  task automatic issue(input int c, input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    set_req(c, a, w, s, d);
    wait_grant(c, exp_rd, exp_err);
    cycle();
    req_valid[c] = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() > 0 && b < 20) begin
      cycle();
      b++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    hreset    = 1'b1;
    req_valid = '0;
    sb.delete();
    repeat (2) cycle();
    hreset = 1'b0;
  endtask

  int   cnt [N];
  int   order[$];
  int   pend;
  int   g;
  logic [31:0] a_tmp;

  initial begin
    hreset    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_size  = '0;
    req_wdata = '0;
    repeat (2) cycle();

    // Reset values, including req_ready held low while reset is active.
    set_req(0, 32'h100, 1'b0, 3'd2, '0);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_hwrite", 64'(hwrite), 64'd0);
    chk("rst_hsize", 64'(hsize), 64'd0);
    chk("rst_hwstrb", 64'(hwstrb), 64'd0);
    chk("rst_hwdata", 64'(hwdata), 64'd0);
    chk("rst_hburst", 64'(hburst), 64'd0);
    chk("rst_stall", 64'(stall_flag), 64'd0);
    hreset = 1'b0;
    cycle();

    // Single zero-wait read from client 0.
    cfg_fixed = 1'b1;
    cfg_rdata = 32'hDEAD_BEEF;
    issue(0, 32'h100, 1'b0, 3'd2, '0, 32'hDEAD_BEEF, 1'b0);
    chk("t1_htrans_nonseq", 64'(htrans), 64'h2);
    chk("t1_haddr", 64'(haddr), 64'h100);
    chk("t1_hwrite", 64'(hwrite), 64'd0);
    chk("t1_hwstrb", 64'(hwstrb), 64'hF);
    cycle();
    chk("t1_htrans_data", 64'(htrans), 64'd0);
    cycle();
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    chk("t1_latency", 64'(last_resp_cyc - t_grant), 64'd3);
    cfg_fixed = 1'b0;

    // Round robin: three clients continuously valid, three reads each.
    do_reset();
    for (int c = 0; c < N; c++) begin
      cnt[c] = 0;
      set_req(c, 32'h1000 + 32'(c) * 32'h100, 1'b0, 3'd2, '0);
    end
    pend = -1;
    for (int it = 0; it < 200 && order.size() < 9; it++) begin
      if (pend >= 0) begin
        if (cnt[pend] < 3)
          set_req(pend, 32'h1000 + 32'(pend) * 32'h100 + 32'(cnt[pend]) * 4, 1'b0, 3'd2, '0);
        else
          req_valid[pend] = 1'b0;
      end
      pend = -1;
      #1;
      if (req_ready !== '0) begin
        chk("rr_onehot", 64'($countones(req_ready)), 64'd1);
        g = 0;
        for (int c = 0; c < N; c++) if (req_ready[c]) g = c;
        a_tmp = req_addr[g*AW +: AW];
        sb.push_back('{client: g, rdata: a_tmp ^ 32'h5A5A_0000, err: 1'b0});
        order.push_back(g);
        cnt[g]++;
        pend = g;
      end
      cycle();
    end
    if (pend >= 0 && cnt[pend] >= 3) req_valid[pend] = 1'b0;
    req_valid = '0;
    chk("rr_grant_count", 64'(order.size()), 64'd9);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("rr_order_%0d", i), 64'(order[i]), 64'(i % 3));
    drain();

    // Byte write from client 1: lane 3 strobe, data on hwdata in the data phase.
    issue(1, 32'h203, 1'b1, 3'd0, 32'hAA, 32'h0, 1'b0);
    chk("t3_hwstrb", 64'(hwstrb), 64'h8);
    chk("t3_hwrite", 64'(hwrite), 64'd1);
    chk("t3_hsize", 64'(hsize), 64'd0);
    chk("t3_hwdata_addr", 64'(hwdata), 64'd0);
    cycle();
    chk("t3_hwdata_data", 64'(hwdata), 64'hAA);
    drain();

    // Misaligned word write and oversize read: rejected without bus activity.
    issue(1, 32'h102, 1'b1, 3'd2, 32'h55, 32'h0, 1'b1);
    chk("rej_htrans_a", 64'(htrans), 64'd0);
    cycle();
    chk("rej_htrans_b", 64'(htrans), 64'd0);
    drain();
    issue(2, 32'h0, 1'b0, 3'd3, '0, 32'h0, 1'b1);
    chk("rej2_htrans", 64'(htrans), 64'd0);
    drain();
    chk("rej_no_dphase", 64'(dp_active), 64'd0);

    // Three data-phase wait states then an error response.
    chk("stall_before", 64'(stall_flag), 64'd0);
    cfg_wait = 3;
    cfg_err  = 1'b1;
    issue(0, 32'h300, 1'b0, 3'd2, '0, 32'h0, 1'b1);
    drain();
    chk("t4_latency", 64'(last_resp_cyc - t_grant), 64'd6);
    chk("stall_after", 64'(stall_flag), 64'd1);
    cfg_err = 1'b0;

    // Reset in the middle of a data phase drops the response and resets the pointer.
    issue(1, 32'h400, 1'b0, 3'd2, '0, 32'h0, 1'b0);
    cycle();
    hreset = 1'b1;
    sb.delete();
    cycle();
    chk("mid_rst_htrans", 64'(htrans), 64'd0);
    chk("mid_rst_haddr", 64'(haddr), 64'd0);
    chk("mid_rst_resp", 64'(resp_valid), 64'd0);
    chk("mid_rst_stall", 64'(stall_flag), 64'd0);
    hreset   = 1'b0;
    cfg_wait = 0;
    repeat (4) cycle();
    set_req(0, 32'h500, 1'b0, 3'd2, '0);
    set_req(2, 32'h600, 1'b0, 3'd1, '0);
    #1;
    chk("post_rst_first_grant", 64'(req_ready), 64'b001);
    if (req_ready[0]) sb.push_back('{client: 0, rdata: 32'h500 ^ 32'h5A5A_0000, err: 1'b0});
    cycle();
    req_valid[0] = 1'b0;
    wait_grant(2, 32'h600 ^ 32'h5A5A_0000, 1'b0);
    cycle();
    req_valid[2] = 1'b0;
    drain();
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
